// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire reader.
//   state_t        : reader FSM states
//   FRAME_BITS     : bits in one sensor frame
//   BYTE_*         : byte positions inside the 40-bit frame (byte 0 = LSB)
//   us_to_cycles() : converts a microsecond duration to clock cycles
//   frame_byte()   : extracts one byte from a frame by byte index
package dht11_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_RELEASE,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } state_t;

  localparam int FRAME_BITS    = 40;
  localparam int BYTE_HUM_INT  = 4;
  localparam int BYTE_HUM_DEC  = 3;
  localparam int BYTE_TEMP_INT = 2;
  localparam int BYTE_TEMP_DEC = 1;
  localparam int BYTE_CSUM     = 0;

  // Multiply before dividing so clocks that are not whole MHz keep precision.
  function automatic logic [31:0] us_to_cycles(input longint unsigned clk_hz,
                                               input longint unsigned us);
    longint unsigned c;
    c = (clk_hz * us) / 64'd1_000_000;
    return c[31:0];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f,
                                            input int idx);
    return f[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Conditions the raw DHT11 line for the reader FSM.
// Optional feature macro: DHT_GLITCH_FILTER_EN (adds a FILT_CYC-sample
// persistence filter after the synchronizer; default build has none).
//   clk, reset_n : clock, async active-low reset
//   line_in      : raw open-drain line (idles high via pull-up)
//   rise, fall   : one-cycle pulses on clean-line edges
module dht11_line_sync
`ifdef DHT_GLITCH_FILTER_EN
#(
  parameter int unsigned FILT_CYC = 100
)
`endif
(
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       clean;
  logic       prev;

  // Reset to 1: the idle line is pulled high, so no edge fires out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], line_in};
  end

`ifdef DHT_GLITCH_FILTER_EN
  localparam int unsigned CW = $clog2(FILT_CYC + 1);
  logic [CW-1:0] cnt;

  // The clean level flips only once FILT_CYC consecutive samples disagree
  // with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean <= 1'b1;
      cnt   <= '0;
    end else if (sync[1] == clean) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT_CYC - 1)) begin
      clean <= sync[1];
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign clean = sync[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b1;
    else          prev <= clean;
  end

  assign rise = clean & ~prev;
  assign fall = ~clean & prev;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 temperature/humidity single-wire master.
// Polls the sensor, times response and 40 data bits, verifies the checksum
// and publishes the bytes. Optional feature macro: DHT_GLITCH_FILTER_EN
// (input persistence filter, see dht11_line_sync).
//   clk, reset_n       : clock, async active-low reset
//   dht_io             : open-drain sensor line, driven 0 or Z only
//   hum_int/hum_dec    : humidity bytes of the last good frame
//   temp_int/temp_dec  : temperature bytes of the last good frame
//   data_ready         : one-cycle pulse, new values valid
//   checksum_err       : one-cycle pulse, frame received with bad checksum
//   timeout_err        : one-cycle pulse, expected edge never arrived
//   busy               : high from start pulse until frame end or abort
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned POLL_PERIOD_MS = 2000,
  parameter int unsigned START_LOW_US   = 20000,
  parameter int unsigned TIMEOUT_US     = 200,
  parameter int unsigned BIT_THRESH_US  = 48
) (
  input  logic       clk,
  input  logic       reset_n,
  inout  wire        dht_io,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic       data_ready,
  output logic       checksum_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam logic [31:0] POLL_CYC    = us_to_cycles(CLK_FREQ_HZ, POLL_PERIOD_MS * 1000);
  localparam logic [31:0] START_CYC   = us_to_cycles(CLK_FREQ_HZ, START_LOW_US);
  localparam logic [31:0] TIMEOUT_CYC = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam logic [31:0] THRESH_CYC  = us_to_cycles(CLK_FREQ_HZ, BIT_THRESH_US);

  state_t                state;
  logic [31:0]           timer;
  logic [FRAME_BITS-1:0] shreg;
  logic [5:0]            bit_cnt;
  logic                  drive_low;
  logic                  rise, fall;
  logic                  timed_out;
  logic [7:0]            sum;

  // Open drain: only ever pull low, otherwise let the pull-up own the line.
  assign dht_io = drive_low ? 1'b0 : 1'bz;

`ifdef DHT_GLITCH_FILTER_EN
  localparam logic [31:0] FILT_RAW = us_to_cycles(CLK_FREQ_HZ, 1);
  localparam int unsigned FILT_CYC = (FILT_RAW == 0) ? 1 : int'(FILT_RAW);
  dht11_line_sync #(.FILT_CYC(FILT_CYC)) u_sync (
`else
  dht11_line_sync u_sync (
`endif
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (dht_io),
    .rise    (rise),
    .fall    (fall)
  );

  // Every state waiting on the sensor shares the same edge deadline.
  assign timed_out = (state inside {S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH})
                     && (timer >= TIMEOUT_CYC);

  assign sum = frame_byte(shreg, BYTE_HUM_INT) + frame_byte(shreg, BYTE_HUM_DEC)
             + frame_byte(shreg, BYTE_TEMP_INT) + frame_byte(shreg, BYTE_TEMP_DEC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      drive_low    <= 1'b0;
      busy         <= 1'b0;
      data_ready   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
      hum_int      <= '0;
      hum_dec      <= '0;
      temp_int     <= '0;
      temp_dec     <= '0;
    end else begin
      data_ready   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
      timer        <= timer + 32'd1;
      if (timed_out) begin
        state       <= S_IDLE;
        timer       <= '0;
        busy        <= 1'b0;
        timeout_err <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (timer >= POLL_CYC - 32'd1) begin
            state     <= S_START_LOW;
            timer     <= '0;
            drive_low <= 1'b1;
            busy      <= 1'b1;
          end
          S_START_LOW: if (timer >= START_CYC - 32'd1) begin
            state     <= S_RELEASE;
            timer     <= '0;
            drive_low <= 1'b0;
          end
          S_RELEASE: if (fall) begin
            state <= S_RESP_LOW;
            timer <= '0;
          end
          S_RESP_LOW: if (rise) begin
            state <= S_RESP_HIGH;
            timer <= '0;
          end
          S_RESP_HIGH: if (fall) begin
            state   <= S_BIT_LOW;
            timer   <= '0;
            bit_cnt <= '0;
          end
          S_BIT_LOW: if (rise) begin
            state <= S_BIT_HIGH;
            timer <= '0;
          end
          // Timer was cleared on the rising edge, so it holds the high width.
          S_BIT_HIGH: if (fall) begin
            shreg   <= {shreg[FRAME_BITS-2:0], (timer > THRESH_CYC)};
            bit_cnt <= bit_cnt + 6'd1;
            timer   <= '0;
            state   <= (bit_cnt == 6'(FRAME_BITS - 1)) ? S_CHECK : S_BIT_LOW;
          end
          S_CHECK: begin
            state <= S_IDLE;
            timer <= '0;
            busy  <= 1'b0;
            if (sum == frame_byte(shreg, BYTE_CSUM)) begin
              hum_int    <= frame_byte(shreg, BYTE_HUM_INT);
              hum_dec    <= frame_byte(shreg, BYTE_HUM_DEC);
              temp_int   <= frame_byte(shreg, BYTE_TEMP_INT);
              temp_dec   <= frame_byte(shreg, BYTE_TEMP_DEC);
              data_ready <= 1'b1;
            end else begin
              checksum_err <= 1'b1;
            end
          end
          default: begin
            state     <= S_IDLE;
            timer     <= '0;
            drive_low <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Self-checking bench for dht11_reader. A behavioural sensor answers each
// start pulse; expected bytes come from decoding the chosen bit-high widths
// with the threshold rule and the modulo-256 checksum rule.
module tb_dht11_reader;

  localparam int CLK_HZ   = 2_000_000;
  localparam int POLL_MS  = 1;
  localparam int START_US = 100;
  localparam int TO_US    = 200;
  localparam int THR_US   = 48;
  localparam int CPU      = CLK_HZ / 1_000_000;
  localparam int POLL_CYC = POLL_MS * 1000 * CPU;
  localparam int TO_CYC   = TO_US * CPU;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sens_low = 1'b0;
  wire        dht_io;
  logic [7:0] temp_int, temp_dec, hum_int, hum_dec;
  logic       data_ready, checksum_err, timeout_err, busy;

  pullup (dht_io);
  assign dht_io = sens_low ? 1'b0 : 1'bz;

  dht11_reader #(
    .CLK_FREQ_HZ(CLK_HZ), .POLL_PERIOD_MS(POLL_MS), .START_LOW_US(START_US),
    .TIMEOUT_US(TO_US), .BIT_THRESH_US(THR_US)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dht_io(dht_io),
    .temp_int(temp_int), .temp_dec(temp_dec), .hum_int(hum_int), .hum_dec(hum_dec),
    .data_ready(data_ready), .checksum_err(checksum_err),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int dr_cnt = 0, ce_cnt = 0, te_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (data_ready)   dr_cnt <= dr_cnt + 1;
    if (checksum_err) ce_cnt <= ce_cnt + 1;
    if (timeout_err)  te_cnt <= te_cnt + 1;
  end

  int vecs = 0, errs = 0;
  int hi_us [40];
  int m_hi = 0, m_hd = 0, m_ti = 0, m_td = 0;   // last-good reference values

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int val, input int lo, input int hi);
    vecs++;
    assert (val >= lo && val <= hi) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic wait_line(input logic lvl, input int limit, input string tag, output int t);
    t = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (dht_io === lvl) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      vecs++;
      errs++;
      $display("FAIL %s: line never reached %0b within %0d cycles", tag, lvl, limit);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $fatal(1, "bench aborted");
    end
  endtask

  task automatic drive(input bit low, input int us);
    sens_low = low;
    repeat (us * CPU) @(negedge clk);
  endtask

  // Sensor reply after host release; returns early (line released) at abort_at.
  task automatic send_bits(input int abort_at);
    drive(0, 20);
    drive(1, 80);
    drive(0, 80);
    for (int i = 0; i < 40; i++) begin
      if (i == abort_at) begin
        sens_low = 1'b0;
        return;
      end
      drive(1, 25);
      drive(0, hi_us[i]);
    end
    drive(1, 25);
    sens_low = 1'b0;
  endtask

  // mode 0: nominal 26/70us, 1: threshold 47/49us, 2: random in-range widths
  task automatic set_widths(input logic [39:0] f, input int mode);
    for (int i = 0; i < 40; i++) begin
      case (mode)
        0:       hi_us[i] = f[39-i] ? 70 : 26;
        1:       hi_us[i] = f[39-i] ? 49 : 47;
        default: hi_us[i] = f[39-i] ? int'($urandom_range(75, 60)) : int'($urandom_range(30, 22));
      endcase
    end
  endtask

  task automatic run_frame(input logic [39:0] f, input int mode, input string tag, output int t_low);
    logic [39:0] e;
    int s, d0, c0, t0, t_hi;
    bit good;
    set_widths(f, mode);
    for (int i = 0; i < 40; i++) e[39-i] = (hi_us[i] > THR_US);
    s = int'(e[39:32]) + int'(e[31:24]) + int'(e[23:16]) + int'(e[15:8]);
    good = ((s % 256) == int'(e[7:0]));
    wait_line(1'b0, 3 * POLL_CYC, {tag, ".start"}, t_low);
    wait_line(1'b1, 4 * START_US * CPU, {tag, ".release"}, t_hi);
    chk_rng({tag, ".start_len"}, t_hi - t_low, START_US * CPU, START_US * CPU + 2);
    chk({tag, ".busy_hi"}, busy, 1);
    d0 = dr_cnt; c0 = ce_cnt; t0 = te_cnt;
    send_bits(-1);
    repeat (10) @(negedge clk);
    if (good) begin
      m_hi = e[39:32]; m_hd = e[31:24]; m_ti = e[23:16]; m_td = e[15:8];
    end
    chk({tag, ".data_ready"}, dr_cnt - d0, good ? 1 : 0);
    chk({tag, ".checksum_err"}, ce_cnt - c0, good ? 0 : 1);
    chk({tag, ".timeout_err"}, te_cnt - t0, 0);
    chk({tag, ".hum_int"}, hum_int, m_hi);
    chk({tag, ".hum_dec"}, hum_dec, m_hd);
    chk({tag, ".temp_int"}, temp_int, m_ti);
    chk({tag, ".temp_dec"}, temp_dec, m_td);
    chk({tag, ".busy_lo"}, busy, 0);
  endtask

  initial begin
    int t0, t1, t_rel, t_to, d0, c0, e0;
    bit line_bad;
    logic [39:0] f;
    logic [7:0] cs;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.hum_int", hum_int, 0);
    chk("rst.temp_int", temp_int, 0);
    chk("rst.data_ready", data_ready, 0);
    chk("rst.timeout_err", timeout_err, 0);
    chk("rst.busy", busy, 0);
    chk("rst.line", dht_io, 1);
    reset_n = 1'b1;
    t0 = cyc;

    // Known frame: 55 %RH, 25.5 C
    run_frame(40'h37_00_19_05_55, 0, "frameA", t1);
    chk_rng("frameA.first_poll", t1 - t0, POLL_CYC, POLL_CYC + 4);
    chk("frameA.hum_int_55", hum_int, 8'd55);
    chk("frameA.temp_int_25", temp_int, 8'd25);

    // Same frame with bad checksum: outputs must hold
    run_frame(40'h37_00_19_05_54, 0, "frameB", t1);
    chk("frameB.temp_dec_5", temp_dec, 8'd5);

    // Threshold neighbourhood 47/49us
    f[39:8] = 32'hA5_3C_96_0F;
    f[7:0]  = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    run_frame(f, 1, "thresh", t1);

    // Random frames, some with a corrupted checksum
    for (int r = 0; r < 2; r++) begin
      f[39:8] = $urandom;
      cs = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      if ($urandom_range(1, 0) == 1) cs = cs ^ (8'h01 << $urandom_range(7, 0));
      f[7:0] = cs;
      run_frame(f, 2, $sformatf("rand%0d", r), t1);
    end

    // Silent sensor: timeout after TIMEOUT_US, line stays released
    wait_line(1'b0, 3 * POLL_CYC, "silent.start", t1);
    wait_line(1'b1, 4 * START_US * CPU, "silent.release", t_rel);
    d0 = dr_cnt; c0 = ce_cnt; e0 = te_cnt;
    line_bad = 1'b0;
    t_to = -1;
    for (int k = 0; k < 4 * TO_CYC; k++) begin
      @(negedge clk);
      if (timeout_err) begin
        t_to = cyc;
        break;
      end
      if (dht_io !== 1'b1) line_bad = 1'b1;
    end
    chk_rng("silent.timeout_delay", t_to - t_rel, TO_CYC, TO_CYC + 3);
    chk("silent.line_released", line_bad, 0);
    @(negedge clk);
    chk("silent.busy_lo", busy, 0);
    chk("silent.timeout_once", te_cnt - e0, 1);
    chk("silent.no_other_pulse", (dr_cnt - d0) + (ce_cnt - c0), 0);
    chk("silent.hum_int_kept", hum_int, m_hi);
    wait_line(1'b0, 3 * POLL_CYC, "silent.next_start", t1);
    chk_rng("silent.poll_gap", t1 - t_to, POLL_CYC, POLL_CYC + 3);

    // Reset during bit 20
    wait_line(1'b1, 4 * START_US * CPU, "rstmid.release", t1);
    set_widths(40'h12_34_56_78_14, 0);
    send_bits(20);
    d0 = dr_cnt; c0 = ce_cnt; e0 = te_cnt;
    reset_n = 1'b0;
    #1;
    m_hi = 0; m_hd = 0; m_ti = 0; m_td = 0;
    chk("rstmid.hum_int", hum_int, m_hi);
    chk("rstmid.hum_dec", hum_dec, m_hd);
    chk("rstmid.temp_int", temp_int, m_ti);
    chk("rstmid.temp_dec", temp_dec, m_td);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.line", dht_io, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    t0 = cyc;
    chk("rstmid.no_pulse", (dr_cnt - d0) + (ce_cnt - c0) + (te_cnt - e0), 0);
    run_frame(40'h2D_00_17_03_47, 2, "after_rst", t1);
    chk_rng("after_rst.first_poll", t1 - t0, POLL_CYC, POLL_CYC + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
